// File: rtl/natalius_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// natalius_prog_loader_pkg
// Shared definitions for the Natalius program loader: loader state encoding,
// failure-cause codes reported on err_code, and the widths of the byte stream
// fields and the SRAM port-0 interface.
// -----------------------------------------------------------------------------
package natalius_prog_loader_pkg;

    // Byte stream field widths
    localparam int BYTE_W = 8;     // one received byte / checksum width
    localparam int LEN_W  = 16;    // {len_hi, len_lo} word count

    // SRAM port-0 widths
    localparam int ADDR_W = 11;    // word address
    localparam int WORD_W = 16;    // instruction word

    // Loader states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    // Failure causes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_LEN  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM = 2'b11;

endpackage

// File: rtl/natalius_idle_timer.sv
// -----------------------------------------------------------------------------
// natalius_idle_timer
// Counts consecutive idle clock cycles while the loader waits for a byte.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   enable   1 while the loader is in a byte-receiving state
//   clear    restart the count (byte accepted or a new load starting)
//   expired  1 during the TIMEOUT-th consecutive idle cycle, so the loader
//            leaves on the edge that ends that cycle
// -----------------------------------------------------------------------------
module natalius_idle_timer #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count holds at LAST; the loader leaves the waiting state on the
    // same edge, after which enable drops and the count returns to zero.
    always_comb begin
        count_d = count_q;
        if (!enable || clear) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = enable && !clear && (count_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/natalius_prog_loader.sv
// -----------------------------------------------------------------------------
// natalius_prog_loader
// Receives a program image as a byte stream and writes it into the Natalius
// instruction SRAM while holding the CPU in reset.
// Stream: len_hi, len_lo, N words (high byte first), checksum byte; the mod-256
// sum of every byte including the checksum must be zero.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start                     one-cycle request to begin a load
//   rx_data/rx_valid/rx_ready byte stream handshake
//   csb0/web0/wmask0/addr0/din0  SRAM port-0 write interface
//   cpu_hold                  1 keeps the processor in reset
//   busy/done/err/err_code    load status
// -----------------------------------------------------------------------------
module natalius_prog_loader
    import natalius_prog_loader_pkg::*;
#(
    parameter int TIMEOUT   = 65535,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              csb0,
    output logic              web0,
    output logic [1:0]        wmask0,
    output logic [ADDR_W-1:0] addr0,
    output logic [WORD_W-1:0] din0,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_WORDS - 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              csb0_q, csb0_d;
    logic              web0_q, web0_d;
    logic [1:0]        wmask0_q, wmask0_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [WORD_W-1:0] din0_q, din0_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              active;
    logic              accept;
    logic              start_load;
    logic              timer_expired;
    logic [LEN_W-1:0]  new_len;
    logic [BYTE_W-1:0] new_sum;
    logic [LEN_W-1:0]  next_words;

    // Receiving states; the handshake and the idle timer are live only here.
    always_comb begin
        active     = (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
        accept     = active && rx_valid;
        start_load = start && (state_q inside {IDLE, DONE, ERROR});
    end

    assign rx_ready = active;

    natalius_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (active),
        .clear   (accept || start_load),
        .expired (timer_expired)
    );

    // Next-state and output logic. The SRAM strobes default to inactive so a
    // write lasts exactly the one cycle after the low byte is accepted.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hi_d       = hi_q;
        idx_d      = idx_q;
        words_d    = words_q;
        sum_d      = sum_q;
        csb0_d     = 1'b1;
        web0_d     = 1'b1;
        wmask0_d   = 2'b00;
        addr0_d    = addr0_q;
        din0_d     = din0_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        new_len    = {len_q[LEN_W-1:BYTE_W], rx_data};
        new_sum    = sum_q + rx_data;
        next_words = words_q + LEN_W'(1);

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d    = LEN_HI;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    sum_d      = '0;
                    idx_d      = '0;
                    words_d    = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[LEN_W-1:BYTE_W] = rx_data;
                    sum_d   = new_sum;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    sum_d = new_sum;
                    len_d = new_len;
                    if (new_len == '0 || new_len > MAX_LEN) begin
                        state_d    = ERROR;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        cpu_hold_d = 1'b1;
                        err_code_d = ERR_BAD_LEN;
                    end else begin
                        idx_d   = '0;
                        words_d = '0;
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    sum_d   = new_sum;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                // The write is registered, so it still reaches the SRAM even
                // if a later cycle moves the FSM into ERROR.
                if (accept) begin
                    sum_d    = new_sum;
                    csb0_d   = 1'b0;
                    web0_d   = 1'b0;
                    wmask0_d = 2'b11;
                    addr0_d  = idx_q;
                    din0_d   = {hi_q, rx_data};
                    idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
                    words_d  = next_words;
                    state_d  = (next_words == len_q) ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (accept) begin
                    sum_d = new_sum;
                    if (new_sum == '0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        cpu_hold_d = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Expiry is only possible in a receiving state with no byte accepted,
        // so it never competes with a transition made above.
        if (timer_expired) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            cpu_hold_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    // State and output registers; reset aborts any load and any write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            hi_q       <= '0;
            idx_q      <= '0;
            words_q    <= '0;
            sum_q      <= '0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= 2'b00;
            addr0_q    <= '0;
            din0_q     <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
            sum_q      <= sum_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            wmask0_q   <= wmask0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign csb0     = csb0_q;
    assign web0     = web0_q;
    assign wmask0   = wmask0_q;
    assign addr0    = addr0_q;
    assign din0     = din0_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_natalius_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_natalius_prog_loader
// Drives program-load byte streams into natalius_prog_loader and compares the
// SRAM writes and final status against a stream-level reference model.
// -----------------------------------------------------------------------------
module tb_natalius_prog_loader;

    localparam int TIMEOUT   = 16;
    localparam int MAX_WORDS = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        csb0;
    logic        web0;
    logic [1:0]  wmask0;
    logic [10:0] addr0;
    logic [15:0] din0;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_t;

    wr_t        wrQ[$];
    logic [7:0] streamQ[$];
    logic       prevWrite = 1'b0;

    always #5 clk = ~clk;

    natalius_prog_loader #(
        .TIMEOUT   (TIMEOUT),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .csb0     (csb0),
        .web0     (web0),
        .wmask0   (wmask0),
        .addr0    (addr0),
        .din0     (din0),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Records every SRAM write and checks that the strobes drop right after.
    always @(negedge clk) begin
        if (prevWrite) begin
            checkOutput("wrRelease", {28'd0, csb0, web0, wmask0}, 32'hC);
        end
        prevWrite = 1'b0;
        if (rst && !csb0 && !web0) begin
            wrQ.push_back('{addr0, din0, wmask0});
            prevWrite = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Appends the byte that makes the mod-256 total of the stream zero.
    task automatic appendGoodChecksum();
        logic [7:0] total;
        total = 8'h00;
        foreach (streamQ[i]) total += streamQ[i];
        streamQ.push_back(8'h00 - total);
    endtask

    task automatic sendByte(input logic [7:0] b);
        int waitCycles;
        waitCycles = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!rx_ready) begin
            checkOutput("rxReadyWait", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic startLoad(input string name);
        wrQ.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, ".busyStart"}, {28'd0, busy, cpu_hold, done, err}, 32'hC);
    endtask

    // Reference model: outcome decided from the whole stream.
    task automatic checkLoad(input string name);
        int         n;
        int         nWords;
        logic [7:0] total;
        logic       expDone;
        logic [1:0] expCode;
        n = {streamQ[0], streamQ[1]};
        if (n == 0 || n > MAX_WORDS) begin
            expDone = 1'b0;
            expCode = 2'b01;
            nWords  = 0;
        end else begin
            total = 8'h00;
            foreach (streamQ[i]) total += streamQ[i];
            expDone = (total == 8'h00);
            expCode = expDone ? 2'b00 : 2'b11;
            nWords  = n;
        end
        checkOutput({name, ".done"}, done, expDone);
        checkOutput({name, ".err"}, err, !expDone);
        checkOutput({name, ".errCode"}, err_code, expCode);
        checkOutput({name, ".cpuHold"}, cpu_hold, !expDone);
        checkOutput({name, ".busy"}, busy, 1'b0);
        checkOutput({name, ".nWrites"}, wrQ.size(), nWords);
        for (int i = 0; i < nWords && i < wrQ.size(); i++) begin
            checkOutput({name, ".wrAddr"}, wrQ[i].addr, i);
            checkOutput({name, ".wrData"}, wrQ[i].data, {streamQ[2 + 2 * i], streamQ[3 + 2 * i]});
            checkOutput({name, ".wrMask"}, wrQ[i].mask, 2'b11);
        end
    endtask

    task automatic applyStimulus(input string name, input int gapMax, input bit pokeStart);
        startLoad(name);
        foreach (streamQ[i]) begin
            repeat ($urandom_range(gapMax, 0)) @(negedge clk);
            if (pokeStart && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            sendByte(streamQ[i]);
        end
        @(negedge clk);
        #1;
        checkLoad(name);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".rxReady"}, rx_ready, 1'b0);
        checkOutput({name, ".strobes"}, {csb0, web0, wmask0}, 4'hC);
        checkOutput({name, ".addr0"}, addr0, 11'd0);
        checkOutput({name, ".din0"}, din0, 16'd0);
        checkOutput({name, ".status"}, {cpu_hold, busy, done, err, err_code}, 6'b100000);
    endtask

    initial begin
        int n;
        $display("[TB] natalius_prog_loader bench starting");

        repeat (2) @(negedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b1;

        // Two words; checksum byte 40 brings the mod-256 total to zero.
        streamQ = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        applyStimulus("twoWords", 0, 1'b0);

        streamQ = '{8'h00, 8'h00};
        applyStimulus("lenZero", 1, 1'b0);

        streamQ = '{8'h08, 8'h01};
        applyStimulus("lenTooBig", 1, 1'b0);

        streamQ = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
        applyStimulus("badSum", 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(6, 1);
            streamQ.delete();
            streamQ.push_back(8'h00);
            streamQ.push_back(8'(n));
            for (int w = 0; w < 2 * n; w++) streamQ.push_back(8'($urandom));
            appendGoodChecksum();
            if ($urandom_range(3, 0) == 0) streamQ[streamQ.size() - 1] ^= 8'h5A;
            applyStimulus($sformatf("rand%0d", r), 3, r == 2);
        end

        streamQ.delete();
        streamQ.push_back(8'h08);
        streamQ.push_back(8'h00);
        for (int w = 0; w < 2 * MAX_WORDS; w++) streamQ.push_back(8'($urandom));
        appendGoodChecksum();
        applyStimulus("maxWords", 0, 1'b0);

        // Idle after len_lo: the 16th idle cycle ends in ERROR.
        streamQ = '{8'h00, 8'h02};
        startLoad("timeout");
        sendByte(8'h00);
        sendByte(8'h02);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("timeout.early", {err, busy}, 2'b01);
        @(negedge clk);
        #1;
        checkOutput("timeout.err", err, 1'b1);
        checkOutput("timeout.errCode", err_code, 2'b10);
        checkOutput("timeout.hold", {cpu_hold, busy, rx_ready}, 3'b100);
        checkOutput("timeout.nWrites", wrQ.size(), 0);

        // Reset in the middle of a word, with the low byte offered meanwhile.
        startLoad("midReset");
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        rst      = 1'b0;
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        #1;
        checkResetValues("midReset");
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midReset.nWrites", wrQ.size(), 0);
        checkResetValues("afterReset");
        streamQ = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        appendGoodChecksum();
        applyStimulus("freshLoad", 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
